// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and a long-latency unit.
// It tracks outstanding long-latency destinations and bounds long-latency starvation.
module rf_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_stall_o,
  input  logic              lu_issue_i,
  input  logic [4:0]        lu_issue_rd_i,
  input  logic              lu_valid_i,
  input  logic [4:0]        lu_rd_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              lu_ready_o,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic              id_rd_we_i,
  output logic              hazard_o,
  output logic              rf_we_o,
  output logic [4:0]        rf_rd_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic [31:0]       busy_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_WAIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [31:0]      busy_q, busy_d, busy_masked;
  logic             force_lu, wb_grant, lu_grant;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    force_lu = (state_q == ST_FORCE);
    wb_grant = wb_valid_i & ~force_lu;
    lu_grant = lu_valid_i & (force_lu | ~wb_valid_i);
    cnt_inc  = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    state_d  = ST_IDLE;
    cnt_d    = '0;

    case (state_q)
      ST_IDLE, ST_WAIT: begin
        // A refused LU cycle counts toward the starvation bound; anything else restarts it.
        if (lu_valid_i && !lu_grant) begin
          cnt_d   = cnt_inc[CNT_W-1:0];
          state_d = (cnt_inc >= MAX_CNT) ? ST_FORCE : ST_WAIT;
        end
      end
      default: ;
    endcase

    busy_d = busy_q;
    if (lu_grant) busy_d[lu_rd_i] = 1'b0;
    if (lu_issue_i) busy_d[lu_issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;

    // The register file forwards same-cycle write data, so a retiring LU write is not a hazard.
    busy_masked = busy_q;
    if (lu_grant) busy_masked[lu_rd_i] = 1'b0;
  end

  always_comb begin
    wb_stall_o = 1'b0;
    lu_ready_o = 1'b0;
    hazard_o   = 1'b0;
    rf_we_o    = 1'b0;
    rf_rd_o    = '0;
    rf_data_o  = '0;
    busy_o     = '0;
    if (!rst_i) begin
      wb_stall_o = force_lu;
      lu_ready_o = lu_grant;
      hazard_o   = busy_masked[id_rs1_i] | busy_masked[id_rs2_i]
                 | (id_rd_we_i & busy_masked[id_rd_i]);
      if (wb_grant) begin
        rf_rd_o   = wb_rd_i;
        rf_data_o = wb_data_i;
      end else if (lu_grant) begin
        rf_rd_o   = lu_rd_i;
        rf_data_o = lu_data_i;
      end
      rf_we_o = (wb_grant | lu_grant) & (rf_rd_o != 5'd0);
      busy_o  = busy_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule
